// File: rtl/fpall_issue_arbiter.sv
// fpall_issue_arbiter: round-robin issue of N_REQ requesters onto one
// fixed-latency FP datapath. A tag pipeline routes each result back to the
// requester that issued it. Sqrt/Div issues hold off further issues for a
// fixed window.
module fpall_issue_arbiter #(
    parameter int N_REQ        = 2,
    parameter int LATENCY      = 4,
    parameter int BLOCK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [2*N_REQ-1:0]    req_opcode,
    input  logic [N_REQ-1:0]      req_fmt,
    input  logic [32*N_REQ-1:0]   req_x,
    input  logic [32*N_REQ-1:0]   req_y,
    output logic [1:0]            fpu_opcode,
    output logic                  fpu_fmt,
    output logic [31:0]           fpu_x,
    output logic [31:0]           fpu_y,
    input  logic [31:0]           fpu_r,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BLOCK_CYCLES + 1);

    typedef enum logic {ISSUE, LOCK} state_t;

    state_t             state;
    logic [CNT_W-1:0]   lock_cnt;
    logic [IDW-1:0]     ptr;

    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic               hs;
    logic [1:0]         grant_op;

    // Tag pipeline: stage k holds the op whose datapath inputs were loaded k cycles ago.
    logic [LATENCY:0]   tag_vld_p;
    logic [IDW-1:0]     tag_id_p [0:LATENCY];

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int             s;
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        s         = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            s = int'(ptr) + k;
            if (s >= N_REQ) s = s - N_REQ;
            idx = IDW'(s);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // Handshake only while issuing and not in reset; ready is one-hot of the grant.
    always_comb begin
        hs        = grant_any && (state == ISSUE) && !rst;
        req_ready = hs ? (N_REQ'(1) << grant_id) : '0;
        grant_op  = req_opcode[{grant_id, 1'b0} +: 2];
    end

    // Control FSM: priority pointer and Sqrt/Div lockout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            lock_cnt <= '0;
            ptr      <= '0;
        end else begin
            if (hs) begin
                if (int'(grant_id) == N_REQ - 1) ptr <= '0;
                else                             ptr <= grant_id + 1'b1;
            end
            case (state)
                ISSUE: begin
                    if (hs && grant_op[1] && (BLOCK_CYCLES > 1)) begin
                        state    <= LOCK;
                        lock_cnt <= CNT_W'(BLOCK_CYCLES - 1);
                    end
                end
                LOCK: begin
                    if (lock_cnt == CNT_W'(1)) state <= ISSUE;
                    lock_cnt <= lock_cnt - 1'b1;
                end
                default: state <= ISSUE;
            endcase
        end
    end

    // Stage p0: capture granted operands onto the datapath inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_opcode <= 2'b00;
            fpu_fmt    <= 1'b0;
            fpu_x      <= '0;
            fpu_y      <= '0;
        end else if (hs) begin
            fpu_opcode <= grant_op;
            fpu_fmt    <= req_fmt[grant_id];
            fpu_x      <= req_x[{grant_id, 5'b0} +: 32];
            fpu_y      <= req_y[{grant_id, 5'b0} +: 32];
        end
    end

    // Tag valid shift register; reset discards every in-flight op.
    always_ff @(posedge clk) begin
        if (rst) tag_vld_p <= '0;
        else     tag_vld_p <= {tag_vld_p[LATENCY-1:0], hs};
    end

    // Tag id shift register, moves alongside the valid bits.
    always_ff @(posedge clk) begin
        tag_id_p[0] <= grant_id;
        for (int k = 1; k <= LATENCY; k++) tag_id_p[k] <= tag_id_p[k-1];
    end

    // Response stage: strobe the owner and capture the datapath result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tag_vld_p[LATENCY] ? (N_REQ'(1) << tag_id_p[LATENCY]) : '0;
            if (tag_vld_p[LATENCY]) rsp_data <= fpu_r;
        end
    end

    assign busy = (|tag_vld_p) || (state == LOCK) || (|rsp_valid);

endmodule

// File: tb/tb_fpall_issue_arbiter.sv
// Bench for fpall_issue_arbiter: default instance driven from a per-cycle
// vector table, plus a BLOCK_CYCLES=1 instance for back-to-back Sqrt issue.
module tb_fpall_issue_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: defaults (N=2, LATENCY=4, BLOCK=8)
    logic        rst_a;
    logic [1:0]  vld_a, rdy_a, rv_a, fmt_a;
    logic [3:0]  op_a;
    logic [63:0] x_a, y_a;
    logic [1:0]  fop_a;
    logic        ffmt_a, busy_a;
    logic [31:0] fx_a, fy_a, fr_a, rd_a;

    fpall_issue_arbiter dut_a (
        .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_ready(rdy_a),
        .req_opcode(op_a), .req_fmt(fmt_a), .req_x(x_a), .req_y(y_a),
        .fpu_opcode(fop_a), .fpu_fmt(ffmt_a), .fpu_x(fx_a), .fpu_y(fy_a),
        .fpu_r(fr_a), .rsp_valid(rv_a), .rsp_data(rd_a), .busy(busy_a)
    );

    // ---------------- instance B: BLOCK_CYCLES = 1
    logic        rst_b;
    logic [1:0]  vld_b, rdy_b, rv_b, fmt_b;
    logic [3:0]  op_b;
    logic [63:0] x_b, y_b;
    logic [1:0]  fop_b;
    logic        ffmt_b, busy_b;
    logic [31:0] fx_b, fy_b, fr_b, rd_b;

    fpall_issue_arbiter #(.N_REQ(2), .LATENCY(4), .BLOCK_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(vld_b), .req_ready(rdy_b),
        .req_opcode(op_b), .req_fmt(fmt_b), .req_x(x_b), .req_y(y_b),
        .fpu_opcode(fop_b), .fpu_fmt(ffmt_b), .fpu_x(fx_b), .fpu_y(fy_b),
        .fpu_r(fr_b), .rsp_valid(rv_b), .rsp_data(rd_b), .busy(busy_b)
    );

    // Datapath stand-in: 1.0+2.0=3.0 for the reference Add, a mixing hash otherwise.
    function automatic logic [31:0] model(input logic [1:0] op, input logic fmt,
                                          input logic [31:0] x, input logic [31:0] y);
        if (op == 2'b00 && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        return x ^ {y[30:0], y[31]} ^ {29'b0, fmt, op};
    endfunction

    // Four register stages from fpu_* to fpu_r for each instance.
    logic [31:0] dpa [0:3];
    logic [31:0] dpb [0:3];
    always @(posedge clk) begin
        dpa[0] <= model(fop_a, ffmt_a, fx_a, fy_a);
        dpb[0] <= model(fop_b, ffmt_b, fx_b, fy_b);
        for (int k = 1; k < 4; k++) begin
            dpa[k] <= dpa[k-1];
            dpb[k] <= dpb[k-1];
        end
    end
    assign fr_a = dpa[3];
    assign fr_b = dpb[3];

    // ---------------- checking
    int checks = 0;
    int errors = 0;
    int row_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row_no, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [3:0]  op;
        logic [1:0]  fmt;
        logic [63:0] x, y;
        logic [1:0]  ex_rdy, ex_rv;
        logic [31:0] ex_rd;
        logic        ex_busy;
        logic        chk_fpu;
        logic [1:0]  ex_fop;
        logic        ex_ffmt;
        logic [31:0] ex_fx, ex_fy;
    } vec_t;

    vec_t vq[$];

    // Operand context shared by the rows of one scenario.
    logic [1:0]  c_op0, c_op1, c_fmt;
    logic [31:0] c_x0, c_y0, c_x1, c_y1;

    task automatic rowf(input logic r, input logic [1:0] vld, input logic [1:0] rdy,
                        input logic [1:0] rv, input logic [31:0] rd, input logic bz,
                        input logic cf, input logic [1:0] fop, input logic ffmt,
                        input logic [31:0] fx, input logic [31:0] fy);
        vec_t v;
        v.rst = r; v.vld = vld; v.op = {c_op1, c_op0}; v.fmt = c_fmt;
        v.x = {c_x1, c_x0}; v.y = {c_y1, c_y0};
        v.ex_rdy = rdy; v.ex_rv = rv; v.ex_rd = rd; v.ex_busy = bz;
        v.chk_fpu = cf; v.ex_fop = fop; v.ex_ffmt = ffmt; v.ex_fx = fx; v.ex_fy = fy;
        vq.push_back(v);
    endtask

    task automatic row(input logic r, input logic [1:0] vld, input logic [1:0] rdy,
                       input logic [1:0] rv, input logic [31:0] rd, input logic bz);
        rowf(r, vld, rdy, rv, rd, bz, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] d0, d1;
        // idle inputs, both instances in reset
        rst_a = 1'b1; vld_a = '0; op_a = '0; fmt_a = '0; x_a = '0; y_a = '0;
        rst_b = 1'b1; vld_b = '0; op_b = '0; fmt_b = '0; x_b = '0; y_b = '0;

        // ---- single Add from req0, reset row first checks reset state
        c_op0 = 2'b00; c_op1 = 2'b00; c_fmt = 2'b00;
        c_x0 = 32'h3F800000; c_y0 = 32'h40000000; c_x1 = 32'h0; c_y1 = 32'h0;
        rowf(1, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b00, 1'b0, 32'h0, 32'h0);
        row(0, 2'b01, 2'b01, 2'b00, 0, 0);
        rowf(0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 1'b0, 32'h3F800000, 32'h40000000);
        for (int i = 2; i <= 5; i++) row(0, 2'b00, 2'b00, 2'b00, 0, 1);
        row(0, 2'b00, 2'b00, 2'b01, 32'h40400000, 1);
        row(0, 2'b00, 2'b00, 2'b00, 0, 0);
        row(1, 2'b00, 2'b00, 2'b00, 0, 0);

        // ---- both requesters Mul: alternating grants and responses
        c_op0 = 2'b01; c_op1 = 2'b01; c_fmt = 2'b00;
        c_x0 = 32'h11111111; c_y0 = 32'h22222222; c_x1 = 32'h33333333; c_y1 = 32'h44444444;
        d0 = model(2'b01, 1'b0, c_x0, c_y0);
        d1 = model(2'b01, 1'b0, c_x1, c_y1);
        row(0, 2'b11, 2'b01, 2'b00, 0, 0);
        rowf(0, 2'b11, 2'b10, 2'b00, 0, 1, 1, 2'b01, 1'b0, c_x0, c_y0);
        rowf(0, 2'b11, 2'b01, 2'b00, 0, 1, 1, 2'b01, 1'b0, c_x1, c_y1);
        row(0, 2'b11, 2'b10, 2'b00, 0, 1);
        row(0, 2'b00, 2'b00, 2'b00, 0, 1);
        row(0, 2'b00, 2'b00, 2'b00, 0, 1);
        row(0, 2'b00, 2'b00, 2'b01, d0, 1);
        row(0, 2'b00, 2'b00, 2'b10, d1, 1);
        row(0, 2'b00, 2'b00, 2'b01, d0, 1);
        row(0, 2'b00, 2'b00, 2'b10, d1, 1);
        row(0, 2'b00, 2'b00, 2'b00, 0, 0);
        row(1, 2'b00, 2'b00, 2'b00, 0, 0);

        // ---- req1 Div locks out req0 (BF16 Add held across the lockout)
        c_op0 = 2'b00; c_op1 = 2'b11; c_fmt = 2'b01;
        c_x0 = 32'h12345678; c_y0 = 32'h9ABCDEF0; c_x1 = 32'hAAAA0000; c_y1 = 32'h00005555;
        d1 = model(2'b11, 1'b0, c_x1, c_y1);
        d0 = model(2'b00, 1'b1, c_x0, c_y0);
        row(0, 2'b10, 2'b10, 2'b00, 0, 0);
        rowf(0, 2'b01, 2'b00, 2'b00, 0, 1, 1, 2'b11, 1'b0, c_x1, c_y1);
        for (int i = 2; i <= 5; i++) row(0, 2'b01, 2'b00, 2'b00, 0, 1);
        row(0, 2'b01, 2'b00, 2'b10, d1, 1);
        row(0, 2'b01, 2'b00, 2'b00, 0, 1);
        row(0, 2'b01, 2'b01, 2'b00, 0, 0);
        rowf(0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 2'b00, 1'b1, c_x0, c_y0);
        for (int i = 10; i <= 13; i++) row(0, 2'b00, 2'b00, 2'b00, 0, 1);
        row(0, 2'b00, 2'b00, 2'b01, d0, 1);
        row(0, 2'b00, 2'b00, 2'b00, 0, 0);
        row(1, 2'b00, 2'b00, 2'b00, 0, 0);

        // ---- three Adds then reset mid-flight: nothing may come back
        c_op0 = 2'b00; c_op1 = 2'b00; c_fmt = 2'b01;
        c_x0 = 32'h40A00000; c_y0 = 32'h3F000000; c_x1 = 32'h0; c_y1 = 32'h0;
        row(0, 2'b01, 2'b01, 2'b00, 0, 0);
        row(0, 2'b01, 2'b01, 2'b00, 0, 1);
        row(0, 2'b01, 2'b01, 2'b00, 0, 1);
        row(1, 2'b01, 2'b00, 2'b00, 0, 1);
        rowf(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 5; i <= 10; i++) row(0, 2'b00, 2'b00, 2'b00, 0, 0);

        // apply table to instance A
        @(posedge clk); #1;
        foreach (vq[i]) begin
            row_no = i;
            rst_a = vq[i].rst; vld_a = vq[i].vld; op_a = vq[i].op;
            fmt_a = vq[i].fmt; x_a = vq[i].x; y_a = vq[i].y;
            #1;
            chk("req_ready", 32'(rdy_a), 32'(vq[i].ex_rdy));
            chk("rsp_valid", 32'(rv_a), 32'(vq[i].ex_rv));
            chk("busy", 32'(busy_a), 32'(vq[i].ex_busy));
            if (vq[i].ex_rv != 2'b00) chk("rsp_data", rd_a, vq[i].ex_rd);
            if (vq[i].chk_fpu) begin
                chk("fpu_opcode", 32'(fop_a), 32'(vq[i].ex_fop));
                chk("fpu_fmt", 32'(ffmt_a), 32'(vq[i].ex_ffmt));
                chk("fpu_x", fx_a, vq[i].ex_fx);
                chk("fpu_y", fy_a, vq[i].ex_fy);
            end
            @(posedge clk); #1;
        end
        rst_a = 1'b0; vld_a = '0;

        // ---- instance B: back-to-back Sqrt from both requesters, no lockout
        op_b = {2'b10, 2'b10}; fmt_b = 2'b00;
        x_b = {32'h0BAD0001, 32'h0C0FFEE0}; y_b = {32'h00000000, 32'h00000000};
        d0 = model(2'b10, 1'b0, 32'h0C0FFEE0, 32'h0);
        d1 = model(2'b10, 1'b0, 32'h0BAD0001, 32'h0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            logic [1:0] er, ev;
            row_no = 1000 + c;
            vld_b = (c < 4) ? 2'b11 : 2'b00;
            #1;
            er = (c < 4) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            ev = (c >= 6 && c <= 9) ? ((c % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("b_req_ready", 32'(rdy_b), 32'(er));
            chk("b_rsp_valid", 32'(rv_b), 32'(ev));
            chk("b_busy", 32'(busy_b), (c >= 1 && c <= 9) ? 32'd1 : 32'd0);
            if (ev != 2'b00) chk("b_rsp_data", rd_b, (ev == 2'b01) ? d0 : d1);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpall_issue_arbiter.md
# fpall_issue_arbiter

Shares one fixed-latency shared FP datapath (Add/Mul/Sqrt/Div, FP32/BF16) between `N_REQ` independent requesters. Round-robin arbitration picks one request per cycle, registers its operands onto the datapath inputs, and tracks in-flight operations with a tag pipeline. Each result is returned to the requester that issued it. Sqrt/Div issues lock out further issues for a fixed window.

## Interface
- `N_REQ`, default 2: number of requesters, ≥2.
- `LATENCY`, default 4: datapath register stages from `fpu_x/y/opcode/fmt` to `fpu_r`, ≥1.
- `BLOCK_CYCLES`, default 8: issue lockout window after a Sqrt/Div handshake, counted including the handshake cycle, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: request present, one bit per requester.
- `req_ready` out N_REQ: request accepted this cycle.
- `req_opcode` in 2·N_REQ: per-requester opcode (00 Add, 01 Mul, 10 Sqrt, 11 Div).
- `req_fmt` in N_REQ: per-requester format (0 FP32, 1 BF16).
- `req_x`, `req_y` in 32·N_REQ each: per-requester operands.
- `fpu_opcode` out 2, `fpu_fmt` out 1, `fpu_x` out 32, `fpu_y` out 32: registered datapath inputs.
- `fpu_r` in 32: datapath result.
- `rsp_valid` out N_REQ: one-cycle result strobe to the owning requester.
- `rsp_data` out 32: result, shared by all requesters, qualified by `rsp_valid`.
- `busy` out 1: any op in flight or lockout active.

## Operation
- Handshake: request i transfers on a cycle where `req_valid[i] && req_ready[i]`. The requester holds its opcode, fmt and operands stable while valid and not ready. It must not drop valid before the transfer.
- Arbitration: `req_ready` is one-hot or zero. `req_ready` is purely combinational from `req_valid`, the priority pointer and the FSM state. The first valid requester at or after `ptr`, searching upward with wrap, is granted.
- `ptr` moves to grant+1 mod N_REQ after each handshake and does not move otherwise. `ptr` resets to 0.
- FSM `ISSUE` (issue allowed) and `LOCK` (no issue; all `req_ready` = 0).
  - `ISSUE` → `LOCK` on a Sqrt/Div handshake when BLOCK_CYCLES>1. The lock counter loads BLOCK_CYCLES-1.
  - `LOCK`: the counter decrements each cycle and the FSM returns to `ISSUE` when it reaches 1. Lockout lasts exactly BLOCK_CYCLES-1 cycles.
  - Add/Mul never leave `ISSUE`, so one handshake per cycle is sustained.
- On handshake, the `fpu_*` registers load the granted opcode, fmt, x and y. With no handshake they hold their value.
- Tag pipeline: LATENCY+1 stages of {valid, id}. A handshake inserts {1, grant id}; otherwise {0, –}. The pipeline shifts every cycle.
- When the final stage is valid, `rsp_valid[id]` pulses and `rsp_data` registers `fpu_r`. `rsp_data` holds its value otherwise.
- Results are never stalled: requesters accept `rsp_valid` unconditionally. Fixed latency guarantees in-order, collision-free return.
- `busy` = any tag valid, or state = `LOCK`, or any `rsp_valid` is high.

## Timing
- Reset values: `req_ready` 0 while `rst` is high; `fpu_opcode` 00, `fpu_fmt` 0, `fpu_x`/`fpu_y` 0; `rsp_valid` 0; `rsp_data` 0; `busy` 0; `ptr` 0; state `ISSUE`; all tags invalid.
- Handshake in cycle t: `fpu_*` are valid in cycle t+1, `fpu_r` is sampled at the end of cycle t+1+LATENCY, and `rsp_valid`/`rsp_data` are visible in cycle t+LATENCY+2.
- Sqrt/Div handshake in cycle t: the next handshake is possible at the earliest in cycle t+BLOCK_CYCLES.
- Reset mid-operation: every in-flight tag is discarded, and no `rsp_valid` fires for ops issued before reset. The first cycle after reset deasserts behaves as post-reset idle.
- `req_valid` asserted during `LOCK` waits. Arbitration for it uses `ptr` as of the cycle the lock releases.
- Single requester valid: that requester is granted regardless of `ptr`.

## Test plan
- Req0 Add, X=0x3F800000, Y=0x40000000, handshake at cycle 0, datapath model returns 0x40400000 → `rsp_valid[0]` high only in cycle 6, `rsp_data`=0x40400000, `rsp_valid[1]` stays 0.
- Both requesters continuously valid with Mul after reset → grants 0,1,0,1 on consecutive cycles, responses in cycles 6,7,8,9 to ids 0,1,0,1 with matching data.
- Req1 Div at cycle 0 with req0 Add valid from cycle 1 → `req_ready` all 0 in cycles 1–7, req0 granted in cycle 8, req0 response in cycle 14.
- Three Adds issued at cycles 0–2, `rst` high in cycle 3 → no `rsp_valid` ever for them, `busy`=0 and `fpu_*`=0 in cycle 4.
- Requester holds valid with opcode/operands stable across a lockout → fields observed on `fpu_*` the cycle after its grant exactly match the held values. BF16 fmt=1 propagates to `fpu_fmt`.
- BLOCK_CYCLES=1, back-to-back Sqrt from both requesters → one handshake per cycle, no `LOCK` entry, responses every cycle.
